pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives the freeze/flush inputs of the IF stage register and PC, inserts bubbles into ID/EXE, and freezes the whole pipeline during multi-cycle SRAM accesses.
- Owns the MEM-stage SRAM request/acknowledge handshake, with a timeout watchdog.
- Sits beside the datapath; its inputs come from ID, EXE and MEM stage registers.

---
 rtl/pipeline_hazard_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer and MEM-stage SRAM handshake for the 5-stage pipeline
// Optional macro FORWARDING_EN: with it, only load-use hazards stall.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_taken,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_src1_en,
  input  logic             id_src2_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ack,
  output logic             sram_req,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t         state, state_n;
  logic [TW-1:0]  tmo_cnt;
  logic           tmo_hit;
  logic           mem_busy;
  logic           hazard;
  logic           stall;

  assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mem_r_en | mem_w_en) state_n = REQ;
      REQ:     if (sram_ack | tmo_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef FORWARDING_EN
  assign hazard = exe_mem_r_en & exe_wb_en &
                  ((id_src1_en & (id_src1 == exe_dest)) |
                   (id_src2_en & (id_src2 == exe_dest)));
`else
  logic unused_exe_mem_r_en;
  assign unused_exe_mem_r_en = exe_mem_r_en;
  assign hazard = (id_src1_en & exe_wb_en & (id_src1 == exe_dest)) |
                  (id_src1_en & mem_wb_en & (id_src1 == mem_dest)) |
                  (id_src2_en & exe_wb_en & (id_src2 == exe_dest)) |
                  (id_src2_en & mem_wb_en & (id_src2 == mem_dest));
`endif

  // Freeze starts in the same cycle the access shows up in MEM, before REQ is registered.
  assign mem_busy    = ((state == IDLE) & (mem_r_en | mem_w_en)) | (state == REQ);
  assign stall       = hazard & ~branch_taken & ~mem_busy;
  assign pipe_freeze = mem_busy;
  assign pc_freeze   = mem_busy | stall;
  assign if_freeze   = mem_busy | stall;
  assign if_flush    = branch_taken & ~mem_busy;
  assign id_flush    = (branch_taken | stall) & ~mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sram_req  <= 1'b0;
      tmo_cnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_n;
      sram_req <= (state_n == REQ);
      if (state == REQ && state_n == REQ)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if (state == REQ && tmo_hit && !sram_ack)
        mem_err <= 1'b1;
      if (pc_freeze && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
